// File: rtl/rotate_frame_buffer_pkg.sv
// Shared widths, FSM encodings and beat type for the rotate-stage
// ping-pong frame buffer.
package rotate_frame_buffer_pkg;
    localparam int SAMPLE_W = 16;
    localparam int BEAT_W   = 2 * SAMPLE_W;

    typedef enum logic {W_ACCEPT = 1'b0, W_DROP = 1'b1} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_READ = 1'b1} rd_state_t;

    typedef struct packed {
        logic              last;
        logic [BEAT_W-1:0] data;
    } beat_t;

    function automatic logic [BEAT_W-1:0] pack_iq(input logic [SAMPLE_W-1:0] i,
                                                  input logic [SAMPLE_W-1:0] q);
        return {q, i};
    endfunction
endpackage

// File: rtl/rotate_frame_buffer_if.sv
// AXI-Stream beat channel from the frame buffer toward the IFFT/DMA.
interface rotate_frame_buffer_if;
    import rotate_frame_buffer_pkg::*;

    logic [BEAT_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master(output tdata, output tvalid, output tlast, input tready);
    modport slave(input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rotate_frame_buffer_frame_ram.sv
// Simple dual-port sample store covering both banks; registered read,
// no reset on the array.
module frame_ram #(
    parameter  int DEPTH = 16384,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/rotate_frame_buffer.sv
// Ping-pong frame buffer: captures rotated I/Q frames into two banks and
// replays each held frame as one AXI-Stream packet.
module rotate_frame_buffer
    import rotate_frame_buffer_pkg::*;
#(
    parameter int FFT_POINT  = 8192,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] i_rotate_I_data,
    input  logic signed [SAMPLE_W-1:0] i_rotate_Q_data,
    input  logic                       i_rotate_valid,
    input  logic                       i_rotate_last,
    input  logic                       i_clear,
    rotate_frame_buffer_if.master      m_axis,
    output logic [1:0]                 o_bank_full,
    output logic                       o_overflow
);
    localparam int                    RAM_AW     = $clog2(2 * FFT_POINT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FFT_POINT - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
    localparam logic [RAM_AW-1:0]     BANK1_BASE = RAM_AW'(FFT_POINT);

    wr_state_t             wr_state, wr_state_n;
    rd_state_t             rd_state, rd_state_n;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_cnt, rd_len;
    logic [ADDR_WIDTH-1:0] len [2];
    logic                  wr_bank, rd_bank;
    logic                  ram_we, wr_end, drop;
    logic                  rd_issue, rd_pend, pend_last, pop, rd_done, room;
    logic [1:0]            skid_cnt, occ, full_set, full_clr;
    beat_t                 skid [2];
    beat_t                 incoming;
    logic [BEAT_W-1:0]     ram_q;
    logic [RAM_AW-1:0]     ram_waddr, ram_raddr;

    assign ram_waddr = (wr_bank ? BANK1_BASE : '0) + RAM_AW'(wr_addr);
    assign ram_raddr = (rd_bank ? BANK1_BASE : '0) + RAM_AW'(rd_cnt);

    frame_ram #(.DEPTH(2 * FFT_POINT), .DW(BEAT_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (pack_iq(i_rotate_I_data, i_rotate_Q_data)),
        .re    (rd_issue),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= W_ACCEPT;
        else        wr_state <= wr_state_n;
    end

    // A frame is only refused at its first sample; once started it owns the bank.
    always_comb begin
        wr_state_n = wr_state;
        ram_we     = 1'b0;
        wr_end     = 1'b0;
        drop       = 1'b0;
        case (wr_state)
            W_ACCEPT: if (i_rotate_valid) begin
                if (wr_addr == '0 && o_bank_full[wr_bank]) begin
                    drop = 1'b1;
                    if (!i_rotate_last) wr_state_n = W_DROP;
                end else begin
                    ram_we = 1'b1;
                    wr_end = i_rotate_last || (wr_addr == LAST_ADDR);
                end
            end
            W_DROP: if (i_rotate_valid && i_rotate_last) wr_state_n = W_ACCEPT;
        endcase
    end

    assign full_set = {ram_we & wr_end & wr_bank, ram_we & wr_end & ~wr_bank};
    assign full_clr = {rd_done & rd_bank, rd_done & ~rd_bank};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            wr_bank     <= 1'b0;
            len[0]      <= '0;
            len[1]      <= '0;
            o_bank_full <= '0;
            o_overflow  <= 1'b0;
        end else begin
            if (ram_we) begin
                if (wr_end) begin
                    len[wr_bank] <= wr_addr + ONE;
                    wr_bank      <= ~wr_bank;
                    wr_addr      <= '0;
                end else begin
                    wr_addr <= wr_addr + ONE;
                end
            end
            o_bank_full <= (o_bank_full & ~full_clr) | full_set;
            o_overflow  <= drop | (o_overflow & ~i_clear);
        end
    end

    assign rd_len   = len[rd_bank];
    assign pop      = m_axis.tvalid & m_axis.tready;
    assign rd_done  = pop & skid[0].last;
    assign occ      = skid_cnt + {1'b0, rd_pend};
    // Reads in flight plus buffered beats never exceed the two skid slots.
    assign room     = (occ < 2'd2) | pop;
    assign incoming = {pend_last, ram_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= R_IDLE;
        else        rd_state <= rd_state_n;
    end

    always_comb begin
        rd_state_n = rd_state;
        rd_issue   = 1'b0;
        case (rd_state)
            R_IDLE: if (o_bank_full[rd_bank]) begin
                rd_issue   = 1'b1;
                rd_state_n = R_READ;
            end
            R_READ: begin
                rd_issue = (rd_cnt != rd_len) && room;
                if (rd_done) rd_state_n = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
            skid_cnt  <= '0;
            skid[0]   <= '0;
            skid[1]   <= '0;
        end else begin
            rd_pend   <= rd_issue;
            pend_last <= rd_issue & (rd_cnt == rd_len - ONE);
            if (rd_done) begin
                rd_cnt  <= '0;
                rd_bank <= ~rd_bank;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + ONE;
            end
            case ({rd_pend, pop})
                2'b01: skid[0] <= skid[1];
                2'b10: begin
                    if (skid_cnt == 2'd0) skid[0] <= incoming;
                    else                  skid[1] <= incoming;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid[0] <= incoming;
                    end else begin
                        skid[0] <= skid[1];
                        skid[1] <= incoming;
                    end
                end
                default: ;
            endcase
            skid_cnt <= skid_cnt + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

    assign m_axis.tvalid = (skid_cnt != 2'd0);
    assign m_axis.tdata  = skid[0].data;
    assign m_axis.tlast  = m_axis.tvalid & skid[0].last;
endmodule
